sa_conv_sequencer: RTL
======================

# sa_conv_sequencer

Hardware feeder and result collector for the SA_2x2 convolution array. Holds a 4x4 input tile and a 3x3 filter loaded over a simple write port. On `start` it resets the array, then drives the nine window/filter steps onto the array's A/B inputs. After the array drains it latches the four C outputs and pulses `done`. The block replaces hand-driven stimulus and sits between the tile/filter source and SA_2x2.

## Interface
- `DW`, 8: data width of A, B and C values.
- `DRAIN`, 1: idle cycles (zero inputs) after the last feed step before C is captured; legal range 1..7.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe for tile/filter storage.
- `wr_sel`  in  1  0 = A tile, 1 = B filter.
- `wr_addr`  in  4  row-major index: A 0..15 (A[r][c] at 4(r-1)+(c-1)); B 0..8 (B[r][c] at 3(r-1)+(c-1)).
- `wr_data`  in  DW  value to store.
- `start`  in  1  begin one convolution; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` until `done` rises.
- `done`  out  1  one-cycle pulse; `res_*` valid from this cycle on.
- `sa_reset`  out  1  active-high reset to SA_2x2 (clears accumulators).
- `A_in_11`, `A_in_12`, `A_in_21`, `A_in_22`  out  DW each  array A inputs, registered.
- `B_in_11`, `B_in_12`, `B_in_21`, `B_in_22`  out  DW each  array B inputs, registered, always equal (broadcast).
- `C_out_11`, `C_out_12`, `C_out_21`, `C_out_22`  in  DW each  array accumulator outputs.
- `res_11`, `res_12`, `res_21`, `res_22`  out  DW each  captured results; hold until next capture.

## Operation
- Storage: 16 A registers and 9 B registers, all 0 on reset.
  - Writes are accepted only in IDLE.
  - `wr_en` while busy is ignored.
  - Out-of-range B address (9..15) is ignored.
- FSM: IDLE -> CLEAR -> SETTLE -> FEED -> DRAIN -> CAPTURE -> IDLE.
  - IDLE: array inputs 0, `sa_reset` 0. `start`=1 moves to CLEAR.
  - CLEAR (1 cycle): `sa_reset`=1, A/B inputs 0.
  - SETTLE (1 cycle): `sa_reset`=0, A/B inputs 0.
  - FEED (9 cycles): step k=0..8 with i=k/3, j=k%3.
    - A_in_11=A[1+i][1+j], A_in_12=A[1+i][2+j], A_in_21=A[2+i][1+j], A_in_22=A[2+i][2+j].
    - All B_in = B[3-i][3-j] (flipped filter: B33, B32, B31, B23, …, B11).
  - DRAIN (`DRAIN` cycles): A/B inputs 0.
  - CAPTURE (1 cycle): `res_*` <= `C_out_*`; `done` asserts next cycle; return to IDLE.
- Step counter is 4 bits, 0..8, no wrap beyond 8; it resets to 0 on entering FEED.
- The block does no arithmetic; results are the array's values verbatim (array's own width/wrap rules apply).
- `start` outside IDLE is ignored, with no queuing.
- `start` and `wr_en` in the same IDLE cycle: the write commits, and the new value is used by the run.
- `reset` asserted mid-run:
  - FSM goes to IDLE.
  - All outputs and storage go to 0; `sa_reset` goes to 0.
  - No `done` is issued.

## Timing
- Reset values: `busy`=0, `done`=0, `sa_reset`=0, all `A_in_*`/`B_in_*`=0, all `res_*`=0.
- `start` is sampled at edge E0. `busy` and `sa_reset` are high in cycle 1.
- SETTLE is cycle 2. Feed step k is presented in cycle 3+k, so the last step is in cycle 11.
- DRAIN occupies cycles 12..11+DRAIN. CAPTURE is cycle 12+DRAIN.
- `done`=1 and `busy`=0 in cycle 13+DRAIN. With DRAIN=1: 14 cycles from start edge to `done`.
- A new `start` is accepted in the same cycle `done` is high (back-to-back runs, one cycle gap minimum).
- `res_*` changes only on the CAPTURE edge.

## Test plan
- All A=1, all B=1, start, with SA_2x2 attached -> `done` 14 cycles after start; `res_11..22` = 9,9,9,9; `busy` low with `done`.
- A rows {2,1,3,1},{2,3,2,1},{3,2,2,2},{1,1,1,2}; B rows {1,3,1},{2,1,2},{1,1,3} -> `res_11`=32, `res_12`=27, `res_21`=28, `res_22`=28.
- Same data; monitor array ports -> cycle 3 sees A=(2,1,2,3), B=3; cycle 11 sees A=(2,2,1,2), B=1; `sa_reset` high only in cycle 1; zeros in cycles 2 and 12.
- `start` and `wr_en` (A[1][1]=5) pulsed mid-FEED -> both ignored; results still 32/27/28/28; next run reflects no change.
- `reset` low during FEED step 4 -> all outputs 0 immediately, no `done`; reload all ones, start -> results 9 each.
- Two back-to-back starts (second in the `done` cycle) -> two `done` pulses 14 cycles apart, identical results.

Source files
------------

// File: rtl/sa_conv_sequencer.sv
// Feeder and result collector for the SA_2x2 convolution array: stores a 4x4 tile
// and a 3x3 filter, streams the nine window/filter steps, then captures the four C outputs.
module sa_conv_sequencer #(
  parameter int DW    = 8,
  parameter int DRAIN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          sa_reset,
  output logic [DW-1:0] A_in_11,
  output logic [DW-1:0] A_in_12,
  output logic [DW-1:0] A_in_21,
  output logic [DW-1:0] A_in_22,
  output logic [DW-1:0] B_in_11,
  output logic [DW-1:0] B_in_12,
  output logic [DW-1:0] B_in_21,
  output logic [DW-1:0] B_in_22,
  input  logic [DW-1:0] C_out_11,
  input  logic [DW-1:0] C_out_12,
  input  logic [DW-1:0] C_out_21,
  input  logic [DW-1:0] C_out_22,
  output logic [DW-1:0] res_11,
  output logic [DW-1:0] res_12,
  output logic [DW-1:0] res_21,
  output logic [DW-1:0] res_22
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_FEED, S_DRAIN, S_CAPTURE
  } state_t;

  localparam logic [3:0] LAST_STEP  = 4'd8;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN - 1);

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic [DW-1:0] a_mem [16];
  logic [DW-1:0] b_mem [9];

  logic          feeding;
  logic [3:0]    row_off, base, b_idx;
  logic [DW-1:0] a11_next, a12_next, a21_next, a22_next, b_next;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE:    if (start) state_next = S_CLEAR;
      S_CLEAR:   state_next = S_SETTLE;
      S_SETTLE: begin
        state_next = S_FEED;
        cnt_next   = '0;
      end
      S_FEED: begin
        if (cnt == LAST_STEP) begin
          state_next = S_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) state_next = S_CAPTURE;
        else                   cnt_next   = cnt + 4'd1;
      end
      S_CAPTURE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Window origin for step k is A[1+i][1+j] = a_mem[4i+j] = a_mem[k+i]; the flipped
  // filter tap B[3-i][3-j] is b_mem[8-k].
  always_comb begin
    feeding  = (state_next == S_FEED);
    row_off  = (cnt_next >= 4'd6) ? 4'd2 : (cnt_next >= 4'd3) ? 4'd1 : 4'd0;
    base     = cnt_next + row_off;
    b_idx    = LAST_STEP - cnt_next;
    a11_next = '0;
    a12_next = '0;
    a21_next = '0;
    a22_next = '0;
    b_next   = '0;
    if (feeding) begin
      a11_next = a_mem[base];
      a12_next = a_mem[base + 4'd1];
      a21_next = a_mem[base + 4'd4];
      a22_next = a_mem[base + 4'd5];
      b_next   = b_mem[b_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: the tile and filter stores are reset explicitly; a reset must leave them all zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) a_mem[i] <= '0;
      for (int i = 0; i < 9; i++)  b_mem[i] <= '0;
    end else if (wr_en && state == S_IDLE) begin
      if (!wr_sel)                a_mem[wr_addr] <= wr_data;
      else if (wr_addr < 4'd9)    b_mem[wr_addr] <= wr_data;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      sa_reset <= 1'b0;
      A_in_11  <= '0;
      A_in_12  <= '0;
      A_in_21  <= '0;
      A_in_22  <= '0;
      B_in_11  <= '0;
      B_in_12  <= '0;
      B_in_21  <= '0;
      B_in_22  <= '0;
      res_11   <= '0;
      res_12   <= '0;
      res_21   <= '0;
      res_22   <= '0;
    end else begin
      busy     <= (state_next != S_IDLE);
      done     <= (state == S_CAPTURE);
      sa_reset <= (state_next == S_CLEAR);
      A_in_11  <= a11_next;
      A_in_12  <= a12_next;
      A_in_21  <= a21_next;
      A_in_22  <= a22_next;
      B_in_11  <= b_next;
      B_in_12  <= b_next;
      B_in_21  <= b_next;
      B_in_22  <= b_next;
      if (state == S_CAPTURE) begin
        res_11 <= C_out_11;
        res_12 <= C_out_12;
        res_21 <= C_out_21;
        res_22 <= C_out_22;
      end
    end
  end

endmodule
